alu_pipe_cc: RTL

- Parametrised, pipelined Y86-64 execute-stage ALU. Supersedes the purely combinational 64-bit bitwise units.
- Accepts operand pairs and an ifun code over a valid/ready handshake, and returns registered results two cycles later.
- Maintains the architectural condition-code register (ZF, SF, OF) for the execute stage.

---
 rtl/alu_pipe_cc.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/alu_pipe_cc.sv
// Two-stage Y86-64 execute ALU with valid/ready handshake and a {ZF,SF,OF} condition-code register.
// Define ALU_PIPE_EXT_OPS_EN to add OR, ANDN and CMP (ifun 4..6).
module alu_pipe_cc #(
  parameter int         W        = 64,
  parameter logic [2:0] CC_RESET = 3'b100
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [3:0]   in_ifun,
  input  logic         in_set_cc,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result,
  output logic         out_err,
  output logic         cc_zf,
  output logic         cc_sf,
  output logic         cc_of
);

  localparam logic [3:0] IFUN_ADD  = 4'd0;
  localparam logic [3:0] IFUN_SUB  = 4'd1;
  localparam logic [3:0] IFUN_AND  = 4'd2;
  localparam logic [3:0] IFUN_XOR  = 4'd3;
`ifdef ALU_PIPE_EXT_OPS_EN
  localparam logic [3:0] IFUN_OR   = 4'd4;
  localparam logic [3:0] IFUN_ANDN = 4'd5;
  localparam logic [3:0] IFUN_CMP  = 4'd6;
`endif

  logic         r_s1Valid;
  logic [W-1:0] r_s1A;
  logic [W-1:0] r_s1B;
  logic [3:0]   r_s1Ifun;
  logic         r_s1SetCc;

  logic         r_s2Valid;
  logic [W-1:0] r_s2Result;
  logic         r_s2Err;
  logic         r_s2SetCc;
  logic         r_s2Zf;
  logic         r_s2Sf;
  logic         r_s2Of;

  logic         r_ccZf;
  logic         r_ccSf;
  logic         r_ccOf;

  logic         w_s2Adv;
  logic         w_s1Adv;
  logic         w_accept;
  logic         w_retire;
  logic [W-1:0] w_sum;
  logic [W-1:0] w_diff;
  logic [W-1:0] w_res;
  logic [W-1:0] w_outResult;
  logic         w_passB;
  logic         w_of;
  logic         w_err;
  logic         w_zf;
  logic         w_sf;

  // A stage may move when its successor is empty or draining this cycle.
  assign w_s2Adv  = !r_s2Valid || out_ready;
  assign w_s1Adv  = !r_s1Valid || w_s2Adv;
  assign in_ready = w_s1Adv;
  assign w_accept = in_valid && w_s1Adv;
  assign w_retire = r_s2Valid && out_ready;

  assign w_sum  = r_s1A + r_s1B;
  assign w_diff = r_s1B - r_s1A;

  always_comb begin
    w_res   = '0;
    w_of    = 1'b0;
    w_err   = 1'b0;
    w_passB = 1'b0;
    case (r_s1Ifun)
      IFUN_ADD: begin
        w_res = w_sum;
        w_of  = (r_s1A[W-1] == r_s1B[W-1]) && (w_sum[W-1] != r_s1A[W-1]);
      end
      IFUN_SUB: begin
        w_res = w_diff;
        w_of  = (r_s1A[W-1] != r_s1B[W-1]) && (w_diff[W-1] != r_s1B[W-1]);
      end
      IFUN_AND: w_res = r_s1A & r_s1B;
      IFUN_XOR: w_res = r_s1A ^ r_s1B;
`ifdef ALU_PIPE_EXT_OPS_EN
      IFUN_OR:   w_res = r_s1A | r_s1B;
      IFUN_ANDN: w_res = r_s1B & ~r_s1A;
      // CMP sets flags like SUB but forwards valB untouched.
      IFUN_CMP: begin
        w_res   = w_diff;
        w_of    = (r_s1A[W-1] != r_s1B[W-1]) && (w_diff[W-1] != r_s1B[W-1]);
        w_passB = 1'b1;
      end
`endif
      default: w_err = 1'b1;
    endcase
  end

  assign w_outResult = w_passB ? r_s1B : w_res;
  assign w_zf        = (w_res == '0);
  assign w_sf        = w_res[W-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1Valid <= 1'b0;
      r_s1A     <= '0;
      r_s1B     <= '0;
      r_s1Ifun  <= '0;
      r_s1SetCc <= 1'b0;
    end else if (w_s1Adv) begin
      r_s1Valid <= in_valid;
      if (w_accept) begin
        r_s1A     <= in_a;
        r_s1B     <= in_b;
        r_s1Ifun  <= in_ifun;
        r_s1SetCc <= in_set_cc;
      end
    end
  end

  // S2 only loads when it may advance, so a stalled result holds stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2Valid  <= 1'b0;
      r_s2Result <= '0;
      r_s2Err    <= 1'b0;
      r_s2SetCc  <= 1'b0;
      r_s2Zf     <= 1'b0;
      r_s2Sf     <= 1'b0;
      r_s2Of     <= 1'b0;
    end else if (w_s2Adv) begin
      r_s2Valid <= r_s1Valid;
      if (r_s1Valid) begin
        r_s2Result <= w_outResult;
        r_s2Err    <= w_err;
        r_s2SetCc  <= r_s1SetCc;
        r_s2Zf     <= w_zf;
        r_s2Sf     <= w_sf;
        r_s2Of     <= w_of;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      {r_ccZf, r_ccSf, r_ccOf} <= CC_RESET;
    end else if (w_retire && r_s2SetCc && !r_s2Err) begin
      r_ccZf <= r_s2Zf;
      r_ccSf <= r_s2Sf;
      r_ccOf <= r_s2Of;
    end
  end

  assign out_valid  = r_s2Valid;
  assign out_result = r_s2Result;
  assign out_err    = r_s2Err;
  assign cc_zf      = r_ccZf;
  assign cc_sf      = r_ccSf;
  assign cc_of      = r_ccOf;

endmodule
